// File: rtl/flash_prog.sv
// SPI (mode 0) serial-flash programmer: WREN, page program or 4 KB sector
// erase, then status polling until WIP clears.
module flash_prog #(
    parameter int SCK_HALF = 2,
    parameter int CS_GAP   = 8
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        start,
    input  logic        op,
    input  logic [23:0] addr,
    input  logic [8:0]  len,
    input  logic [7:0]  din,
    input  logic        din_valid,
    output logic        din_ready,
    output logic        busy,
    output logic        done,
    output logic        error,
    output logic        flash_cs_n,
    output logic        flash_sck,
    output logic        flash_si,
    input  logic        flash_so,
    output logic [3:0]  state_dbg
);
    localparam logic [3:0] IDLE   = 4'd0;
    localparam logic [3:0] CHECK  = 4'd1;
    localparam logic [3:0] WREN   = 4'd2;
    localparam logic [3:0] GAP1   = 4'd3;
    localparam logic [3:0] CMD    = 4'd4;
    localparam logic [3:0] DATA   = 4'd5;
    localparam logic [3:0] GAP2   = 4'd6;
    localparam logic [3:0] POLL   = 4'd7;
    localparam logic [3:0] GAP3   = 4'd8;
    localparam logic [3:0] FINISH = 4'd9;

    localparam logic [7:0] HALF_LAST = 8'(SCK_HALF - 1);
    localparam logic [7:0] GAP_LAST  = 8'(CS_GAP - 1);

    logic [3:0]  state;
    logic        op_r, err_r;
    logic [23:0] addr_r;
    logic [8:0]  len_r, cnt;
    logic [2:0]  idx;
    logic [7:0]  hi_cnt;
    logic [7:0]  sh, hcnt;
    logic [3:0]  bits;
    logic        sh_busy, so_bit;
    logic        bad, gap_ok, ld;
    logic [7:0]  ld_val;

    assign bad = !op_r && (len_r == 9'd0 || len_r > 9'd256 ||
                 ({2'b00, addr_r[7:0]} + {1'b0, len_r}) > 10'd256);
    // hi_cnt counts cycles cs_n has been high; every command start waits on it,
    // so the high time also holds across back-to-back operations and after reset.
    assign gap_ok = flash_cs_n && (hi_cnt >= GAP_LAST);

    assign busy      = (state != IDLE);
    assign done      = (state == FINISH);
    assign error     = done && err_r;
    assign state_dbg = state;

    // din handshake: a byte moves on a clk edge where din_valid && din_ready;
    // din_ready never depends on din_valid.
    always_comb begin
        ld        = 1'b0;
        ld_val    = 8'h00;
        din_ready = 1'b0;
        case (state)
            WREN: if (gap_ok) begin ld = 1'b1; ld_val = 8'h06; end
            GAP1: if (gap_ok) begin ld = 1'b1; ld_val = op_r ? 8'h20 : 8'h02; end
            CMD: if (!sh_busy) begin
                case (idx)
                    3'd1:    begin ld = 1'b1; ld_val = addr_r[23:16]; end
                    3'd2:    begin ld = 1'b1; ld_val = addr_r[15:8]; end
                    3'd3:    begin ld = 1'b1; ld_val = addr_r[7:0]; end
                    default: ld = 1'b0;
                endcase
            end
            DATA: begin
                din_ready = !sh_busy && (cnt != len_r);
                if (din_valid && din_ready) begin ld = 1'b1; ld_val = din; end
            end
            GAP2, GAP3: if (gap_ok) begin ld = 1'b1; ld_val = 8'h05; end
            POLL: if (!sh_busy && idx == 3'd1) begin ld = 1'b1; ld_val = 8'h00; end
            default: ld = 1'b0;
        endcase
    end

    // Byte shifter: si set on load and on falling edges, so sampled on rising edges.
    always_ff @(posedge clk) begin
        if (rst) begin
            sh <= 8'h00; bits <= 4'd0; hcnt <= 8'd0; sh_busy <= 1'b0;
            flash_sck <= 1'b0; flash_si <= 1'b0; so_bit <= 1'b0;
        end else if (ld) begin
            sh <= ld_val; flash_si <= ld_val[7]; bits <= 4'd8;
            hcnt <= 8'd0; sh_busy <= 1'b1; flash_sck <= 1'b0;
        end else if (sh_busy) begin
            if (hcnt == HALF_LAST) begin
                hcnt <= 8'd0;
                if (!flash_sck) begin
                    flash_sck <= 1'b1;
                    so_bit    <= flash_so;
                end else begin
                    flash_sck <= 1'b0;
                    sh        <= {sh[6:0], so_bit};
                    flash_si  <= sh[6];
                    bits      <= bits - 4'd1;
                    if (bits == 4'd1) sh_busy <= 1'b0;
                end
            end else begin
                hcnt <= hcnt + 8'd1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) hi_cnt <= 8'd0;
        else if (!flash_cs_n) hi_cnt <= 8'd0;
        else if (hi_cnt != 8'hFF) hi_cnt <= hi_cnt + 8'd1;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE; flash_cs_n <= 1'b1; op_r <= 1'b0; err_r <= 1'b0;
            addr_r <= 24'd0; len_r <= 9'd0; cnt <= 9'd0; idx <= 3'd0;
        end else begin
            case (state)
                IDLE: if (start) begin
                    op_r <= op; addr_r <= addr; len_r <= len;
                    err_r <= 1'b0; cnt <= 9'd0; state <= CHECK;
                end
                CHECK: begin
                    if (bad) begin err_r <= 1'b1; state <= FINISH; end
                    else state <= WREN;
                end
                WREN: begin
                    if (gap_ok) flash_cs_n <= 1'b0;
                    else if (!flash_cs_n && !sh_busy) begin
                        flash_cs_n <= 1'b1; state <= GAP1;
                    end
                end
                GAP1: if (gap_ok) begin
                    flash_cs_n <= 1'b0; idx <= 3'd1; state <= CMD;
                end
                CMD: if (!sh_busy) begin
                    if (idx != 3'd4) idx <= idx + 3'd1;
                    else if (op_r) begin flash_cs_n <= 1'b1; state <= GAP2; end
                    else begin cnt <= 9'd0; state <= DATA; end
                end
                DATA: begin
                    if (din_valid && din_ready) cnt <= cnt + 9'd1;
                    else if (!sh_busy && cnt == len_r) begin
                        flash_cs_n <= 1'b1; state <= GAP2;
                    end
                end
                GAP2, GAP3: if (gap_ok) begin
                    flash_cs_n <= 1'b0; idx <= 3'd1; state <= POLL;
                end
                POLL: if (!sh_busy) begin
                    if (idx == 3'd1) idx <= 3'd2;
                    else begin
                        flash_cs_n <= 1'b1;
                        state <= sh[0] ? GAP3 : FINISH;
                    end
                end
                FINISH: state <= IDLE;
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_flash_prog.sv
// Bench for flash_prog: a behavioural SPI flash monitor checks MOSI command
// streams, chip-select timing and handshake outputs against spec-derived queues.
module tb_flash_prog;
    localparam int SCK_HALF = 2;
    localparam int CS_GAP   = 8;

    logic        clk = 1'b0;
    logic        rst, start, op, din_valid;
    logic [23:0] addr;
    logic [8:0]  len;
    logic [7:0]  din;
    logic        din_ready, busy, done, error;
    logic        flash_cs_n, flash_sck, flash_si;
    logic        flash_so = 1'b0;
    logic [3:0]  state_dbg;

    flash_prog #(.SCK_HALF(SCK_HALF), .CS_GAP(CS_GAP)) dut (
        .clk(clk), .rst(rst), .start(start), .op(op), .addr(addr), .len(len),
        .din(din), .din_valid(din_valid), .din_ready(din_ready), .busy(busy),
        .done(done), .error(error), .flash_cs_n(flash_cs_n), .flash_sck(flash_sck),
        .flash_si(flash_si), .flash_so(flash_so), .state_dbg(state_dbg)
    );

    // clock / reset block
    always #5 clk = ~clk;
    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    // scoreboard state
    int tests = 0, fails = 0;
    logic [8:0]  exp_q[$];        // bit 8 set = byte value not checked
    int          exp_len_q[$];    // expected bytes per cs_n-low command
    logic [7:0]  data_q[$];
    int          op_seq = 0, cs_rise_seq = -1, hi_run = 0;
    int          mosi_bytes = 0, cs_low_cycles = 0, done_cnt = 0, last_mosi = 0;
    int          seg_bits = 0, wip_left = 0, drv_idx = 0, done_cyc = 0;
    logic        prev_cs = 1'b1, prev_sck = 1'b0, prev_si = 1'b0, prev_done = 1'b0;
    logic        in_seg = 1'b0, is_poll = 1'b0, busy_m = 1'b0, cur_op = 1'b0;
    logic        err_seen = 1'b0, halt = 1'b0;
    logic [7:0]  rx = 8'h00, stat = 8'h00;
    logic [8:0]  e;

    task automatic check(input string name, input int got, input int want);
        tests++;
        if (got != want) begin
            fails++;
            $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, got, want, $time);
        end
    endtask

    // compare process + flash model, sampled mid-cycle
    always @(negedge clk) begin
        if (rst) begin
            in_seg = 1'b0; busy_m = 1'b0;
            exp_q.delete(); exp_len_q.delete();
        end else begin
            check("busy", busy, busy_m);
            check("sck_with_cs_high", flash_cs_n & flash_sck, 0);
            check("error_without_done", error & ~done, 0);
            check("done_width", done & prev_done, 0);
            check("din_ready_scope", din_ready & (cur_op | ~busy_m), 0);
            if (!flash_cs_n) cs_low_cycles++;
            if (prev_cs && !flash_cs_n) begin
                check("cs_fall_sck_low", prev_sck | flash_sck, 0);
                if (cs_rise_seq == op_seq) check("cs_gap", hi_run, CS_GAP);
                else check("cs_gap_min", int'(hi_run >= CS_GAP), 1);
                in_seg = 1'b1; seg_bits = 0; is_poll = 1'b0;
            end
            if (in_seg && !prev_sck && flash_sck) begin
                check("si_setup", flash_si, prev_si);
                rx = {rx[6:0], flash_si};
                seg_bits++;
                if (seg_bits % 8 == 0) begin
                    mosi_bytes++;
                    if (exp_q.size() == 0) check("extra_byte", 1, 0);
                    else begin
                        e = exp_q.pop_front();
                        if (!e[8]) check("mosi_byte", rx, e[7:0]);
                    end
                    if (seg_bits == 8 && rx == 8'h05) begin
                        is_poll = 1'b1;
                        stat = {7'($urandom), wip_left > 0};
                        if (wip_left > 0) wip_left--;
                    end
                end
            end
            if (in_seg && prev_sck && !flash_sck && is_poll && seg_bits >= 8 && seg_bits < 16)
                flash_so = stat[15 - seg_bits];
            if (!prev_cs && flash_cs_n) begin
                cs_rise_seq = op_seq;
                if (in_seg) begin
                    check("cs_rise_sck_low", prev_sck | flash_sck, 0);
                    if (exp_len_q.size() == 0) check("extra_cmd", 1, 0);
                    else check("cmd_bits", seg_bits, 8 * exp_len_q.pop_front());
                    in_seg = 1'b0;
                end
            end
            hi_run = flash_cs_n ? hi_run + 1 : 0;
            if (done) begin done_cnt++; err_seen = error; busy_m = 1'b0; end
            else if (start && !busy_m) busy_m = 1'b1;
        end
        prev_cs = flash_cs_n; prev_sck = flash_sck; prev_si = flash_si; prev_done = done;
    end

    // driver tasks
    task automatic build_exp(input logic o, input logic [23:0] a, input int n, input int wip);
        exp_q.push_back(9'h006); exp_len_q.push_back(1);
        exp_q.push_back({1'b0, (o ? 8'h20 : 8'h02)});
        exp_q.push_back({1'b0, a[23:16]});
        exp_q.push_back({1'b0, a[15:8]});
        exp_q.push_back({1'b0, a[7:0]});
        if (!o) foreach (data_q[i]) exp_q.push_back({1'b0, data_q[i]});
        exp_len_q.push_back(o ? 4 : 4 + n);
        for (int p = 0; p <= wip; p++) begin
            exp_q.push_back(9'h005); exp_q.push_back(9'h100); exp_len_q.push_back(2);
        end
    endtask

    task automatic drive_data(input int n, input int stall_after);
        logic xfer;
        drv_idx = 0;
        din_valid = 1'b0;
        while (drv_idx < n && !halt) begin
            @(negedge clk);
            xfer = din_valid && din_ready;
            @(posedge clk); #1;
            if (xfer) drv_idx++;
            if (xfer && drv_idx == stall_after) begin
                din_valid = 1'b0;
                for (int s = 0; s < 50; s++) begin
                    @(negedge clk);
                    if (s >= 40) begin
                        check("stall_sck_low", flash_sck, 0);
                        check("stall_cs_low", flash_cs_n, 0);
                    end
                end
                @(posedge clk); #1;
            end
            if (drv_idx < n && !halt) begin
                din_valid = ($urandom_range(0, 3) != 0);
                din = data_q[drv_idx];
            end else din_valid = 1'b0;
        end
        din_valid = 1'b0;
    endtask

    task automatic pulse_start(input logic o, input logic [23:0] a, input int n);
        @(posedge clk); #1;
        start = 1'b1; op = o; addr = a; len = n[8:0]; op_seq++;
    endtask

    task automatic run_op(input logic o, input logic [23:0] a, input int n,
                          input int wip, input int stall_after, input bit poke);
        bit bad, seen;
        int dc0, mb0, cl0, start_cyc;
        bad = (o == 1'b0) && (n == 0 || n > 256 || (int'(a[7:0]) + n) > 256);
        if (data_q.size() != n) begin
            data_q.delete();
            for (int i = 0; i < n; i++) data_q.push_back(8'($urandom));
        end
        if (!bad) build_exp(o, a, n, wip);
        wip_left = wip; cur_op = o; halt = 1'b0;
        dc0 = done_cnt; mb0 = mosi_bytes; cl0 = cs_low_cycles;
        pulse_start(o, a, n);
        start_cyc = cyc;
        if (o) begin din_valid = 1'b1; din = 8'($urandom); end
        @(posedge clk); #1;
        start = 1'b0; op = 1'($urandom); addr = 24'($urandom); len = 9'($urandom);
        seen = 1'b0;
        fork
            begin
                if (!bad && !o) drive_data(n, stall_after);
            end
            begin
                if (poke && !bad) begin
                    repeat (20) @(posedge clk);
                    #1 start = 1'b1; op = ~o;
                    @(posedge clk); #1 start = 1'b0;
                end
            end
            begin
                for (int c = 0; c < 30000 && !seen; c++) begin
                    @(negedge clk);
                    if (done) begin seen = 1'b1; done_cyc = cyc; end
                end
                halt = 1'b1;
            end
        join
        din_valid = 1'b0;
        repeat (2) @(negedge clk);
        check("done_seen", seen, 1);
        check("done_count", done_cnt - dc0, 1);
        check("error_flag", err_seen, bad);
        check("bytes_left", exp_q.size(), 0);
        check("cmds_left", exp_len_q.size(), 0);
        if (bad) begin
            check("err_latency", done_cyc - start_cyc, 2);
            check("err_cs_low_cycles", cs_low_cycles - cl0, 0);
        end
        last_mosi = mosi_bytes - mb0;
        exp_q.delete(); exp_len_q.delete(); data_q.delete();
        repeat ($urandom_range(0, 5)) @(posedge clk);
    endtask

    task automatic reset_mid_data();
        int dc0;
        bit reached;
        data_q.delete();
        for (int i = 0; i < 8; i++) data_q.push_back(8'($urandom));
        build_exp(1'b0, 24'h000400, 8, 0);
        cur_op = 1'b0; halt = 1'b0; wip_left = 0; reached = 1'b0;
        pulse_start(1'b0, 24'h000400, 8);
        @(posedge clk); #1 start = 1'b0;
        fork
            drive_data(8, -1);
            begin
                for (int c = 0; c < 5000 && !reached; c++) begin
                    @(negedge clk);
                    if (drv_idx >= 3) reached = 1'b1;
                end
                check("rst_reached_data", reached, 1);
                @(posedge clk); #1 rst = 1'b1; halt = 1'b1;
                dc0 = done_cnt;
                @(posedge clk); #1 rst = 1'b0;
                @(negedge clk);
                check("rst_cs_n", flash_cs_n, 1);
                check("rst_sck", flash_sck, 0);
                check("rst_busy", busy, 0);
                check("rst_din_ready", din_ready, 0);
            end
        join
        repeat (40) @(negedge clk);
        check("rst_no_done", done_cnt - dc0, 0);
        exp_q.delete(); exp_len_q.delete(); data_q.delete();
    endtask

    initial begin
        #3ms;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        rst = 1'b1; start = 1'b0; op = 1'b0; addr = 24'd0; len = 9'd0;
        din = 8'd0; din_valid = 1'b0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("reset_cs_n", flash_cs_n, 1);
        check("reset_sck", flash_sck, 0);
        check("reset_si", flash_si, 0);
        check("reset_din_ready", din_ready, 0);
        check("reset_busy", busy, 0);
        check("reset_done", done, 0);
        check("reset_error", error, 0);
        @(posedge clk); #1 rst = 1'b0;

        data_q = '{8'hA5, 8'h5A, 8'h00, 8'hFF};
        run_op(1'b0, 24'h012300, 4, 2, -1, 1'b0);
        check("prog4_mosi_bytes", last_mosi, 15);

        run_op(1'b1, 24'h003000, 0, 0, -1, 1'b0);
        check("erase_mosi_bytes", last_mosi, 7);

        run_op(1'b0, 24'h0000F0, 32, 0, -1, 1'b0);
        check("bad_page_mosi_bytes", last_mosi, 0);

        run_op(1'b0, 24'h004500, 256, 1, 10, 1'b0);
        check("len256_mosi_bytes", last_mosi, 1 + 4 + 256 + 4);

        reset_mid_data();
        run_op(1'b0, 24'h000510, 6, 1, -1, 1'b1);

        run_op(1'b0, 24'h0010FC, 4, 0, -1, 1'b0);
        run_op(1'b0, 24'h0010FD, 4, 0, -1, 1'b0);
        run_op(1'b0, 24'h002000, 0, 0, -1, 1'b0);
        run_op(1'b0, 24'h002000, 300, 0, -1, 1'b0);
        run_op(1'b0, 24'h0030FF, 1, 0, -1, 1'b0);

        for (int i = 0; i < 6; i++)
            run_op(1'($urandom_range(0, 1)), 24'($urandom), $urandom_range(0, 48),
                   $urandom_range(0, 3), -1, (i == 2));

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule

// File: doc/flash_prog.md
FLASH_PROG -- requirements
Module: flash_prog

Interface
REQ-001 SHALL have parameter SCK_HALF, default 2, meaning clk cycles per flash_sck half-period (flash_sck = clk/(2*SCK_HALF)).
REQ-002 SHALL have parameter CS_GAP, default 8, meaning minimum clk cycles flash_cs_n stays high between flash commands.
REQ-003 SHALL have port clk  input  1  system clock (100 MHz fclk); single clock domain.
REQ-004 SHALL have port rst  input  1  reset; synchronous and active-high.
REQ-005 SHALL have port start  input  1  one-cycle request; sampled only in IDLE.
REQ-006 SHALL have port op  input  1  0 = page program (0x02), 1 = 4 KB sector erase (0x20); sampled with start.
REQ-007 SHALL have port addr  input  24  flash byte address; sampled with start.
REQ-008 SHALL have port len  input  9  page-program byte count, 1..256; ignored for erase.
REQ-009 SHALL have port din  input  8  program data byte.
REQ-010 SHALL have port din_valid  input  1  din holds a byte.
REQ-011 SHALL have port din_ready  output  1  block accepts din this cycle.
REQ-012 SHALL have port busy  output  1  operation in progress.
REQ-013 SHALL have port done  output  1  one-cycle completion pulse.
REQ-014 SHALL have port error  output  1  one-cycle pulse coincident with done when the request was rejected.
REQ-015 SHALL have ports flash_cs_n (output, 1), flash_sck (output, 1), flash_si (output, 1), flash_so (input, 1): SPI to serial flash.

Function
REQ-016 SHALL use SPI mode 0: flash_sck idles low; flash_si changes on the falling edge or before the first rising edge; flash_so sampled on the rising edge; MSB first.
REQ-017 SHALL implement states IDLE, CHECK, WREN, GAP1, CMD, DATA, GAP2, POLL, GAP3, FINISH.
REQ-018 IDLE: start=1 latches op/addr/len, busy=1 next cycle, go to CHECK; start while busy SHALL be ignored.
REQ-019 CHECK (1 cycle): when op=0 and (len==0, len>256, or addr[7:0]+len>256), go to FINISH with error; otherwise go to WREN.
REQ-020 WREN: assert cs_n low, shift 0x06, deassert cs_n, go to GAP1.
REQ-021 GAP1/GAP2/GAP3: hold cs_n high, sck low for exactly CS_GAP clk cycles.
REQ-022 CMD: cs_n low; shift opcode (0x02 or 0x20) then addr[23:16], addr[15:8], addr[7:0]; erase deasserts cs_n and goes to GAP2; program goes to DATA with cs_n held low.
REQ-023 DATA: din_ready=1 only when the shifter is empty and bytes remain; a byte transfers on din_valid&din_ready; no valid byte means sck held low, cs_n held low (stall, no clock edges).
REQ-024 DATA: after len bytes have been shifted completely, deassert cs_n, go to GAP2; no further din_ready.
REQ-025 POLL: cs_n low; shift 0x05, then clock 8 bits in from flash_so; cs_n high; bit0 (WIP)=1 means go to GAP3 then repeat POLL, WIP=0 means go to FINISH.
REQ-026 FINISH (1 cycle): done=1, error as per REQ-019, busy=0 next cycle, return to IDLE.
REQ-027 Byte counter SHALL be 9 bits so len=256 counts without wrap.
REQ-028 Polling SHALL be unbounded; no timeout.
REQ-029 flash_cs_n SHALL never go low while flash_sck is high; every cs_n deassertion SHALL follow the last falling sck edge.

Reset
REQ-030 On rst: state IDLE, flash_cs_n=1, flash_sck=0, flash_si=0, din_ready=0, busy=0, done=0, error=0, counters cleared.
REQ-031 rst mid-operation SHALL abandon the operation at the next clk edge without issuing done; the flash command is left incomplete.

Verification
REQ-032 Program addr=0x012300, len=4, din 0xA5,0x5A,0x00,0xFF, flash model WIP=1 for 2 polls -> MOSI bytes 06 | 02 01 23 00 A5 5A 00 FF | 05 x3; done one pulse; error=0.
REQ-033 Erase addr=0x003000, WIP=0 on first poll -> bytes 06 | 20 00 30 00 | 05; din_ready never asserted; done pulse.
REQ-034 Program addr=0x0000F0, len=32 -> error+done in the cycle after CHECK; flash_cs_n stays 1 throughout.
REQ-035 Program len=256 with din_valid low for 50 cycles after byte 10 -> sck frozen low, cs_n low during stall; all 256 bytes in order; done pulse.
REQ-036 Assert rst during DATA byte 3 -> next cycle cs_n=1, sck=0, busy=0; no done; new start then accepted normally.
REQ-037 All scenarios: check CS_GAP=8 high cycles between commands, and mode-0 timing (si stable on each rising sck edge).
